serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new addition; sampled only when busy=0.
REQ-005 a  input  W  operand A; captured on the accepted start edge.
REQ-006 b  input  W  operand B; captured on the accepted start edge.
REQ-007 busy  output  1  high while the operation is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse marking result valid (state DONE).
REQ-009 sum  output  W  registered result; held between completions.
REQ-010 co  output  1  registered carry-out of the MSB nibble; held with sum.

Function
REQ-011 Datapath: exactly one 4-bit nibble adder with carry-in, reused every cycle; no W-bit adder anywhere in the block.
REQ-012 State machine states: IDLE, RUN, DONE.
REQ-013 IDLE + start=1 -> RUN; operands captured, nibble index k=0, internal carry=0.
REQ-014 IDLE + start=0 -> IDLE; no register changes.
REQ-015 RUN, each cycle: add nibble k of A and B plus carry; write 4-bit result into nibble k of a working register; store carry-out as the next carry; increment k.
REQ-016 RUN with k=NIBBLES-1 -> DONE; otherwise remain in RUN.
REQ-017 On the edge entering DONE: sum <= complete working register; co <= final carry.
REQ-018 DONE lasts exactly one cycle, with done=1 and busy=0.
REQ-019 DONE + start=1 -> RUN with new operands captured (back-to-back operation, no idle gap); DONE + start=0 -> IDLE.
REQ-020 start is ignored while busy=1; operands a and b may change freely during RUN without affecting the result.
REQ-021 Latency: start accepted at edge E; busy=1 for cycles E+1..E+NIBBLES; done=1 in cycle E+NIBBLES+1.
REQ-022 Throughput: one result per NIBBLES+1 cycles under continuous start.
REQ-023 Arithmetic: {co,sum} equals a+b computed modulo 2^(W+1); full carry propagates across all nibbles, one nibble per cycle.
REQ-024 sum and co change only on the edge entering DONE or on reset; they are never partially updated.
REQ-025 done and busy are never high in the same cycle.

Reset
REQ-026 rst=1 at an edge forces: state IDLE, k=0, carry=0, working register=0, sum=0, co=0, busy=0, done=0.
REQ-027 rst takes priority over start and over any state, including mid-RUN; an in-flight operation is discarded and done is not asserted for it.
REQ-028 The first start is accepted at the first edge at which rst=0 and start=1.

Verification
REQ-029 NIBBLES=4; a=0x0000, b=0x0001, start pulse at edge E -> busy high in cycles E+1..E+4; done in cycle E+5; sum=0x0001, co=0.
REQ-030 a=0xFFFF, b=0x0001 -> sum=0x0000, co=1 (carry ripples through all 4 nibbles); a=0xAAAA, b=0x5555 -> sum=0xFFFF, co=0.
REQ-031 During RUN, hold start=1 and change a and b to 0x1234 -> the operation in progress is unaffected; no new operation is accepted until IDLE or DONE.
REQ-032 start=1 in the DONE cycle with a=0x000A, b=0x000F -> RUN resumes the next cycle; next done arrives 5 cycles later with sum=0x0019, co=0.
REQ-033 Assert rst for one cycle during RUN cycle 2 -> next cycle busy=0, done=0, sum=0x0000, co=0; no done pulse for the discarded operation.
REQ-034 Randomized check: 1000 random a/b pairs at NIBBLES=4 and NIBBLES=2 -> {co,sum} matches the reference sum a+b at every done pulse.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Serial adder controller: adds two W-bit operands one nibble per clock
// through a single shared 4-bit adder, then presents {co,sum} with a done pulse.
module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 co
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic          carry;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  work;
  logic [W-1:0]  work_next;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [4:0]    nib_sum;

  // The one nibble adder; the working register with nibble k replaced feeds
  // both the RUN update and the final sum capture.
  always_comb begin
    // NOTE: every combinational output gets a default before any partial
    // overwrite, so no path leaves it unassigned and no latch is inferred.
    work_next = work;
    nib_a     = op_a[{k, 2'b00} +: 4];
    nib_b     = op_b[{k, 2'b00} +: 4];
    nib_sum   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
    work_next[{k, 2'b00} +: 4] = nib_sum[3:0];
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      work  <= '0;
      sum   <= '0;
      co    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            k     <= '0;
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= nib_sum[4];
          k     <= k + KW'(1);
          if (k == K_LAST) begin
            sum   <= work_next;
            co    <= nib_sum[4];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          // Back-to-back: a start seen during the done cycle skips IDLE.
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            k     <= '0;
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
